dmem_arbiter: RTL and testbench

Sequencer and two-requester arbiter in front of data_mem. Port 0 is the core load/store unit; port 1 is the DMA/program loader. It accepts one transaction at a time, drives data_mem's write_en/addr/data_in, and waits the memory read latency. It returns a single-cycle response to the granted port and rejects misaligned accesses before they reach memory.

---
 rtl/dmem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and access sequencer in front of data_mem.
// One transaction at a time; misaligned half/word writes are answered with err, never issued.
`timescale 1ns/1ps
module dmem_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MEM_RD_LAT  = 1,
  parameter int unsigned CHECK_ALIGN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [1:0]        we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic [1:0]        we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              err0,
  output logic              err1,
  output logic              busy,
  output logic [1:0]        mem_write_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  typedef enum logic [1:0] {StIdle, StAccess, StWait, StResp} state_e;

  localparam logic [1:0] OpWord = 2'b00;
  localparam logic [1:0] OpHalf = 2'b01;
  localparam logic [1:0] OpRead = 2'b11;
  localparam int unsigned CntW  = 2;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              port_q, port_d;
  logic [1:0]        we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              idle_ok;
  logic              grant0, grant1;
  logic [1:0]        sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              misaligned;
  logic              resp;

  // Gating with rst_n keeps gnt low while reset is asserted, even though state is already IDLE.
  assign idle_ok = (state_q == StIdle) && rst_n;
  assign grant0  = idle_ok && req0 && (!req1 || last_grant_q);
  assign grant1  = idle_ok && req1 && (!req0 || !last_grant_q);

  assign sel_we    = grant1 ? we1    : we0;
  assign sel_addr  = grant1 ? addr1  : addr0;
  assign sel_wdata = grant1 ? wdata1 : wdata0;

  assign misaligned = (CHECK_ALIGN != 0) &&
                      (((sel_we == OpWord) && (sel_addr[1:0] != 2'b00)) ||
                       ((sel_we == OpHalf) && sel_addr[0]));

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    port_d       = port_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (grant0 || grant1) begin
          port_d       = grant1;
          last_grant_d = grant1;
          we_d         = sel_we;
          addr_d       = sel_addr;
          wdata_d      = sel_wdata;
          err_d        = misaligned;
          rdata_d      = '0;
          state_d      = misaligned ? StResp : StAccess;
        end
      end
      StAccess: begin
        if (we_q == OpRead) begin
          cnt_d   = CntW'(MEM_RD_LAT - 1);
          state_d = StWait;
        end else begin
          state_d = StResp;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          rdata_d = mem_data_out;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      we_q         <= OpRead;
      addr_q       <= '0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
    end
  end

  assign gnt0 = grant0;
  assign gnt1 = grant1;
  assign busy = (state_q != StIdle);

  assign resp    = (state_q == StResp);
  assign rvalid0 = resp && !port_q;
  assign rvalid1 = resp && port_q;
  assign rdata0  = rvalid0 ? rdata_q : '0;
  assign rdata1  = rvalid1 ? rdata_q : '0;
  assign err0    = rvalid0 && err_q;
  assign err1    = rvalid1 && err_q;

  // Memory side depends only on registered state/command; no path from req.
  assign mem_write_en = (state_q == StAccess) ? we_q : OpRead;
  assign mem_addr     = addr_q;
  assign mem_data_in  = wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed table, reset corners, random traffic vs a
// transaction-level model, and a MEM_RD_LAT=3 latency check on a second instance.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  logic        clk, rst_n;
  logic        req0, req1, gnt0, gnt1, rvalid0, rvalid1, err0, err1, busy;
  logic [1:0]  we0, we1, mem_write_en;
  logic [31:0] addr0, addr1, wdata0, wdata1, rdata0, rdata1;
  logic [31:0] mem_addr, mem_data_in, mem_data_out;

  logic        b_req1, b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_err0, b_err1, b_busy;
  logic [1:0]  b_we1, b_mem_we;
  logic [31:0] b_addr1, b_wdata1, b_rdata0, b_rdata1;
  logic [31:0] b_mem_addr, b_mem_din, b_mem_dout;

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_RD_LAT(1), .CHECK_ALIGN(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1), .busy(busy),
    .mem_write_en(mem_write_en), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out)
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_RD_LAT(3), .CHECK_ALIGN(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .req0(1'b0), .we0(2'b11), .addr0(32'h0), .wdata0(32'h0),
    .req1(b_req1), .we1(b_we1), .addr1(b_addr1), .wdata1(b_wdata1),
    .gnt0(b_gnt0), .gnt1(b_gnt1), .rvalid0(b_rvalid0), .rvalid1(b_rvalid1),
    .rdata0(b_rdata0), .rdata1(b_rdata1), .err0(b_err0), .err1(b_err1), .busy(b_busy),
    .mem_write_en(b_mem_we), .mem_addr(b_mem_addr), .mem_data_in(b_mem_din),
    .mem_data_out(b_mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data_mem stand-ins: byte arrays, little-endian, synchronous read pipelines.
  bit   [7:0]  env_mem   [256];
  bit   [7:0]  env_mem_b [256];
  logic [7:0]  a_wb, a_hb, b_wb;
  bit   [31:0] a_pipe;
  bit   [31:0] b_pipe [3];

  assign a_wb = {mem_addr[7:2], 2'b00};
  assign a_hb = {mem_addr[7:1], 1'b0};
  assign b_wb = {b_mem_addr[7:2], 2'b00};
  assign mem_data_out = a_pipe;
  assign b_mem_dout   = b_pipe[2];

  always @(posedge clk) begin
    case (mem_write_en)
      2'b00: begin
        env_mem[a_wb]      <= mem_data_in[7:0];
        env_mem[a_wb + 1]  <= mem_data_in[15:8];
        env_mem[a_wb + 2]  <= mem_data_in[23:16];
        env_mem[a_wb + 3]  <= mem_data_in[31:24];
      end
      2'b01: begin
        env_mem[a_hb]      <= mem_data_in[7:0];
        env_mem[a_hb + 1]  <= mem_data_in[15:8];
      end
      2'b10: env_mem[mem_addr[7:0]] <= mem_data_in[7:0];
      default: ;
    endcase
    a_pipe <= {env_mem[a_wb + 3], env_mem[a_wb + 2], env_mem[a_wb + 1], env_mem[a_wb]};
  end

  always @(posedge clk) begin
    if (b_mem_we == 2'b00) begin
      env_mem_b[b_wb]     <= b_mem_din[7:0];
      env_mem_b[b_wb + 1] <= b_mem_din[15:8];
      env_mem_b[b_wb + 2] <= b_mem_din[23:16];
      env_mem_b[b_wb + 3] <= b_mem_din[31:24];
    end
    b_pipe[0] <= {env_mem_b[b_wb + 3], env_mem_b[b_wb + 2], env_mem_b[b_wb + 1], env_mem_b[b_wb]};
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
  end

  // Reference model: expected memory image and round-robin pointer.
  bit [7:0] ref_mem [256];
  bit       ref_last = 1'b1;

  function automatic bit is_misaligned(input logic [1:0] we, input logic [31:0] a);
    return (we == 2'b00 && a[1:0] != 2'b00) || (we == 2'b01 && a[0]);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    int base = int'(a[7:0]) & 252;
    return {ref_mem[base + 3], ref_mem[base + 2], ref_mem[base + 1], ref_mem[base]};
  endfunction

  task automatic ref_write(input logic [1:0] we, input logic [31:0] a, input logic [31:0] d);
    int n = (we == 2'b00) ? 4 : (we == 2'b01) ? 2 : 1;
    int base = int'(a[7:0]) & ~(n - 1);
    for (int i = 0; i < n; i++) ref_mem[base + i] = d[8*i +: 8];
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  // One transaction on the LAT=1 instance. Called just after a rising edge with the DUT idle.
  task automatic serve(input bit r0, input bit r1, input bit hold,
                       output int port, output bit e, output logic [31:0] rd);
    int          win, lat;
    logic [1:0]  wq;
    logic [31:0] aq, dq, exp_rd;
    bit          mis;
    req0   = r0;
    req1   = r1;
    win    = (r0 && r1) ? (ref_last ? 0 : 1) : (r0 ? 0 : 1);
    wq     = win ? we1 : we0;
    aq     = win ? addr1 : addr0;
    dq     = win ? wdata1 : wdata0;
    mis    = is_misaligned(wq, aq);
    exp_rd = (wq == 2'b11) ? ref_read(aq) : 32'h0;
    rd     = 32'h0;
    e      = 1'b0;
    @(negedge clk);
    check("gnt", {gnt0, gnt1}, {win == 0, win == 1});
    check("busy_idle", busy, 1'b0);
    @(posedge clk); #1;
    ref_last = (win == 1);
    if (!mis && wq != 2'b11) ref_write(wq, aq, dq);
    if (!hold) begin
      req0 = 1'b0;
      req1 = 1'b0;
    end
    lat = mis ? 1 : (wq == 2'b11 ? 3 : 2);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      check("busy", busy, 1'b1);
      check("gnt_while_busy", {gnt0, gnt1}, 2'b00);
      check("mem_write_en", mem_write_en, (k == 1 && !mis) ? wq : 2'b11);
      if (!mis) check("mem_addr", mem_addr, aq);
      if (k == 1 && !mis && wq != 2'b11) check("mem_data_in", mem_data_in, dq);
      if (k < lat) begin
        check("rvalid_early", {rvalid0, rvalid1}, 2'b00);
        check("rdata_idle", rdata0 | rdata1, 32'h0);
        check("err_idle", {err0, err1}, 2'b00);
      end else begin
        check("rvalid", win ? {rvalid1, rvalid0} : {rvalid0, rvalid1}, 2'b10);
        check("rdata", win ? rdata1 : rdata0, exp_rd);
        check("rdata_other", win ? rdata0 : rdata1, 32'h0);
        check("err", win ? {err1, err0} : {err0, err1}, {mis, 1'b0});
        rd = win ? rdata1 : rdata0;
        e  = win ? err1 : err0;
      end
      @(posedge clk); #1;
    end
    port = win;
  endtask

  typedef struct {
    int          p;
    logic [1:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int          port;
    bit          e;
    logic [31:0] rd;
    bit          r0, r1;

    vecs[0]  = '{0, 2'b00, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1]  = '{0, 2'b11, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1, 2'b01, 32'h20, 32'h00001234, 1'b0, 32'h0};
    vecs[3]  = '{1, 2'b10, 32'h21, 32'h00000056, 1'b0, 32'h0};
    vecs[4]  = '{1, 2'b11, 32'h20, 32'h0,        1'b0, 32'h00005634};
    vecs[5]  = '{0, 2'b00, 32'h13, 32'hFFFFFFFF, 1'b1, 32'h0};
    vecs[6]  = '{1, 2'b01, 32'h21, 32'h0000FFFF, 1'b1, 32'h0};
    vecs[7]  = '{0, 2'b11, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[8]  = '{0, 2'b11, 32'h12, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[9]  = '{0, 2'b01, 32'h12, 32'h0000CAFE, 1'b0, 32'h0};
    vecs[10] = '{0, 2'b11, 32'h10, 32'h0,        1'b0, 32'hCAFEBEEF};
    vecs[11] = '{1, 2'b10, 32'h13, 32'h000000AB, 1'b0, 32'h0};
    vecs[12] = '{1, 2'b11, 32'h10, 32'h0,        1'b0, 32'hABFEBEEF};

    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 2'b11; we1 = 2'b11;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    b_req1 = 1'b0; b_we1 = 2'b11; b_addr1 = '0; b_wdata1 = '0;

    // Reset values before any clock edge.
    #3;
    check("rst_gnt", {gnt0, gnt1}, 2'b00);
    check("rst_rvalid", {rvalid0, rvalid1, err0, err1}, 4'b0000);
    check("rst_rdata", rdata0 | rdata1, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_mem_we", mem_write_en, 2'b11);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_din", mem_data_in, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed table.
    foreach (vecs[i]) begin
      if (vecs[i].p == 0) begin
        we0 = vecs[i].we; addr0 = vecs[i].addr; wdata0 = vecs[i].wdata;
      end else begin
        we1 = vecs[i].we; addr1 = vecs[i].addr; wdata1 = vecs[i].wdata;
      end
      serve(vecs[i].p == 0, vecs[i].p == 1, 1'b0, port, e, rd);
      check("tbl_port", port, vecs[i].p);
      check("tbl_err", e, vecs[i].err);
      check("tbl_rdata", rd, vecs[i].rdata);
    end

    // Reset during WAIT of a read.
    we0 = 2'b11; addr0 = 32'h10; req0 = 1'b1;
    @(negedge clk);
    check("rstw_gnt0", gnt0, 1'b1);
    @(posedge clk); #1;
    req0 = 1'b0;
    @(posedge clk); #2;
    check("rstw_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rstw_busy", busy, 1'b0);
    check("rstw_mem_we", mem_write_en, 2'b11);
    check("rstw_mem_addr", mem_addr, 32'h0);
    check("rstw_rvalid", {rvalid0, rvalid1}, 2'b00);
    @(negedge clk);
    check("rstw_rvalid_hold", {rvalid0, rvalid1}, 2'b00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ref_last = 1'b1;

    // Reset during the grant cycle of a write: nothing must be latched or written.
    we0 = 2'b00; addr0 = 32'h30; wdata0 = 32'h11223344; req0 = 1'b1;
    @(negedge clk);
    check("rstg_gnt0", gnt0, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("rstg_gnt0_low", gnt0, 1'b0);
    check("rstg_mem_we", mem_write_en, 2'b11);
    @(posedge clk); #1;
    check("rstg_busy", busy, 1'b0);
    req0 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    ref_last = 1'b1;
    we1 = 2'b11; addr1 = 32'h30;
    serve(1'b0, 1'b1, 1'b0, port, e, rd);
    check("rstg_write_absent", rd, 32'h0);

    // Round robin with both ports held: 0,1,0,1,0,1.
    we0 = 2'b11; addr0 = 32'h10; we1 = 2'b11; addr1 = 32'h20;
    for (int i = 0; i < 6; i++) begin
      serve(1'b1, 1'b1, i < 5, port, e, rd);
      check("rr_port", port, i % 2);
    end

    // Random traffic against the model.
    for (int i = 0; i < 80; i++) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      we0 = 2'($urandom_range(0, 3)); addr0 = 32'($urandom_range(0, 255)); wdata0 = $urandom;
      we1 = 2'($urandom_range(0, 3)); addr1 = 32'($urandom_range(0, 255)); wdata1 = $urandom;
      if (!r0 && !r1) begin
        @(negedge clk);
        check("idle_gnt", {gnt0, gnt1}, 2'b00);
        check("idle_busy", busy, 1'b0);
        check("idle_mem_we", mem_write_en, 2'b11);
        @(posedge clk); #1;
      end else begin
        serve(r0, r1, 1'b0, port, e, rd);
      end
    end

    // MEM_RD_LAT=3 instance: write then read on port 1.
    b_we1 = 2'b00; b_addr1 = 32'h40; b_wdata1 = 32'hA5A50F0F; b_req1 = 1'b1;
    @(negedge clk);
    check("lat3_wr_gnt1", {b_gnt0, b_gnt1}, 2'b01);
    @(posedge clk); #1;
    b_req1 = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      check("lat3_wr_mem_we", b_mem_we, (k == 1) ? 2'b00 : 2'b11);
      check("lat3_wr_rvalid", {b_rvalid0, b_rvalid1}, {1'b0, k == 2});
      @(posedge clk); #1;
    end
    b_we1 = 2'b11; b_req1 = 1'b1;
    @(negedge clk);
    check("lat3_rd_gnt1", {b_gnt0, b_gnt1}, 2'b01);
    @(posedge clk); #1;
    b_req1 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("lat3_mem_addr", b_mem_addr, 32'h40);
      check("lat3_mem_we", b_mem_we, 2'b11);
      check("lat3_busy", b_busy, 1'b1);
      check("lat3_rvalid", {b_rvalid0, b_rvalid1}, {1'b0, k == 5});
      check("lat3_rdata", b_rdata1, (k == 5) ? 32'hA5A50F0F : 32'h0);
      check("lat3_err", b_err1, 1'b0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("lat3_idle", b_busy, 1'b0);

    // Final memory image must match the model.
    for (int w = 0; w < 64; w++) begin
      check("mem_image", {env_mem[4*w+3], env_mem[4*w+2], env_mem[4*w+1], env_mem[4*w]},
            ref_read(32'(4 * w)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
